// File: rtl/ysyx_25040111_arbiter_pkg.sv
// ysyx_25040111_arbiter_pkg: grant states, fixed AXI4 fields and the idle-time grant priority.
package ysyx_25040111_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IFU   = 2'd1,
        ARB_LSU_R = 2'd2,
        ARB_LSU_W = 2'd3
    } arb_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_ID     = 4'd0;
    localparam logic [7:0] AXI_LEN    = 8'd0;

    // LSU write beats LSU read, which beats the IFU
    function automatic arb_state_e arb_pick(input logic lsu_aw, input logic lsu_ar, input logic ifu_ar);
        return lsu_aw ? ARB_LSU_W : lsu_ar ? ARB_LSU_R : ifu_ar ? ARB_IFU : ARB_IDLE;
    endfunction

endpackage

// File: rtl/ysyx_25040111_arbiter.sv
// ysyx_25040111_arbiter: IFU/LSU to single AXI4 master arbiter, one locked transaction at a time.
module ysyx_25040111_arbiter
    import ysyx_25040111_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_arvalid,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic [2:0]            ifu_arsize,
    output logic                  ifu_arready,
    output logic                  ifu_rvalid,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [1:0]            ifu_rresp,
    output logic                  ifu_rlast,
    input  logic                  ifu_rready,
    input  logic                  lsu_arvalid,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic [2:0]            lsu_arsize,
    output logic                  lsu_arready,
    output logic                  lsu_rvalid,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [1:0]            lsu_rresp,
    output logic                  lsu_rlast,
    input  logic                  lsu_rready,
    input  logic                  lsu_awvalid,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic [2:0]            lsu_awsize,
    output logic                  lsu_awready,
    input  logic                  lsu_wvalid,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wlast,
    output logic                  lsu_wready,
    output logic                  lsu_bvalid,
    output logic [1:0]            lsu_bresp,
    input  logic                  lsu_bready,
    input  logic                  io_master_awready,
    output logic                  io_master_awvalid,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [3:0]            io_master_awid,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,
    input  logic                  io_master_wready,
    output logic                  io_master_wvalid,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,
    output logic                  io_master_bready,
    input  logic                  io_master_bvalid,
    input  logic [1:0]            io_master_bresp,
    input  logic                  io_master_arready,
    output logic                  io_master_arvalid,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [3:0]            io_master_arid,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    output logic                  io_master_rready,
    input  logic                  io_master_rvalid,
    input  logic [1:0]            io_master_rresp,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic                  io_master_rlast
);

    arb_state_e state_q, state_d;
    logic       idle, ifu_g, lsu_r_g, lsu_w_g, r_done, b_done;

    assign idle    = state_q == ARB_IDLE;
    assign ifu_g   = state_q == ARB_IFU;
    assign lsu_r_g = state_q == ARB_LSU_R;
    assign lsu_w_g = state_q == ARB_LSU_W;

    assign io_master_arvalid = ifu_g ? ifu_arvalid : lsu_r_g & lsu_arvalid;
    assign io_master_araddr  = ifu_g ? ifu_araddr : lsu_r_g ? lsu_araddr : '0;
    assign io_master_arsize  = ifu_g ? ifu_arsize : lsu_r_g ? lsu_arsize : '0;
    assign io_master_arid    = AXI_ID;
    assign io_master_arlen   = AXI_LEN;
    assign io_master_arburst = BURST_INCR;
    assign ifu_arready       = ifu_g & io_master_arready;
    assign lsu_arready       = lsu_r_g & io_master_arready;

    assign io_master_rready = ifu_g ? ifu_rready : lsu_r_g & lsu_rready;
    assign ifu_rvalid       = ifu_g & io_master_rvalid;
    assign ifu_rdata        = ifu_g ? io_master_rdata : '0;
    assign ifu_rresp        = ifu_g ? io_master_rresp : RESP_OKAY;
    assign ifu_rlast        = ifu_g & io_master_rlast;
    assign lsu_rvalid       = lsu_r_g & io_master_rvalid;
    assign lsu_rdata        = lsu_r_g ? io_master_rdata : '0;
    assign lsu_rresp        = lsu_r_g ? io_master_rresp : RESP_OKAY;
    assign lsu_rlast        = lsu_r_g & io_master_rlast;

    // AW, W and B run independently while the write grant is held
    assign io_master_awvalid = lsu_w_g & lsu_awvalid;
    assign io_master_awaddr  = lsu_w_g ? lsu_awaddr : '0;
    assign io_master_awsize  = lsu_w_g ? lsu_awsize : '0;
    assign io_master_awid    = AXI_ID;
    assign io_master_awlen   = AXI_LEN;
    assign io_master_awburst = BURST_INCR;
    assign lsu_awready       = lsu_w_g & io_master_awready;
    assign io_master_wvalid  = lsu_w_g & lsu_wvalid;
    assign io_master_wdata   = lsu_w_g ? lsu_wdata : '0;
    assign io_master_wstrb   = lsu_w_g ? lsu_wstrb : '0;
    assign io_master_wlast   = lsu_w_g & lsu_wlast;
    assign lsu_wready        = lsu_w_g & io_master_wready;
    assign lsu_bvalid        = lsu_w_g & io_master_bvalid;
    assign lsu_bresp         = lsu_w_g ? io_master_bresp : RESP_OKAY;
    assign io_master_bready  = lsu_w_g & lsu_bready;

    assign r_done = (ifu_g | lsu_r_g) & io_master_rvalid & io_master_rready & io_master_rlast;
    assign b_done = io_master_bvalid & io_master_bready;

    always_comb begin
        state_d = idle ? arb_pick(lsu_awvalid, lsu_arvalid, ifu_arvalid) : (r_done | b_done) ? ARB_IDLE : state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_ysyx_25040111_arbiter.sv
// tb_ysyx_25040111_arbiter: random IFU/LSU masters and AXI slave against a transaction-level grant model.
module tb_ysyx_25040111_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [2:0]  lsu_awsize;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        m_awready, m_awvalid, m_wready, m_wvalid, m_wlast, m_bready, m_bvalid;
    logic        m_arready, m_arvalid, m_rready, m_rvalid, m_rlast;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_awid, m_arid, m_wstrb;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;

    always #5 clk = ~clk;

    ysyx_25040111_arbiter dut (
        .clk(clk), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .io_master_awready(m_awready), .io_master_awvalid(m_awvalid), .io_master_awaddr(m_awaddr), .io_master_awid(m_awid),
        .io_master_awlen(m_awlen), .io_master_awsize(m_awsize), .io_master_awburst(m_awburst),
        .io_master_wready(m_wready), .io_master_wvalid(m_wvalid), .io_master_wdata(m_wdata), .io_master_wstrb(m_wstrb),
        .io_master_wlast(m_wlast), .io_master_bready(m_bready), .io_master_bvalid(m_bvalid), .io_master_bresp(m_bresp),
        .io_master_arready(m_arready), .io_master_arvalid(m_arvalid), .io_master_araddr(m_araddr), .io_master_arid(m_arid),
        .io_master_arlen(m_arlen), .io_master_arsize(m_arsize), .io_master_arburst(m_arburst),
        .io_master_rready(m_rready), .io_master_rvalid(m_rvalid), .io_master_rresp(m_rresp), .io_master_rdata(m_rdata),
        .io_master_rlast(m_rlast)
    );

    int checks = 0;
    int errors = 0;
    int owner;          // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
    int nxt_owner;
    int ifu_ph, lr_ph;  // 0 idle, 1 address pending, 2 awaiting data
    int lw_ph;          // 0 idle, 1 write outstanding
    int s_beats;
    int ifu_done, lsu_rd_done, lsu_wr_done;
    bit s_aw, s_w, rst_now, after_rst;
    bit h_ar, h_r, h_r_last, h_aw, h_w, h_b;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] up_flags();
        return {ifu_arready, lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid,
                m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready};
    endfunction

    task automatic check_cycle();
        logic oi, olr, ow, earv, eawv, ewv;
        logic [31:0] ea;
        logic [2:0]  es;
        oi   = owner == 1;
        olr  = owner == 2;
        ow   = owner == 3;
        earv = oi ? ifu_arvalid : (olr & lsu_arvalid);
        ea   = oi ? ifu_araddr : lsu_araddr;
        es   = oi ? ifu_arsize : lsu_arsize;
        eawv = ow & lsu_awvalid;
        ewv  = ow & lsu_wvalid;
        check("ar", 128'({m_arvalid, m_arvalid ? {m_araddr, m_arsize} : 35'd0, m_arid, m_arlen, m_arburst}),
                    128'({earv, earv ? {ea, es} : 35'd0, 4'd0, 8'd0, 2'b01}));
        check("aw", 128'({m_awvalid, m_awvalid ? {m_awaddr, m_awsize} : 35'd0, m_awid, m_awlen, m_awburst}),
                    128'({eawv, eawv ? {lsu_awaddr, lsu_awsize} : 35'd0, 4'd0, 8'd0, 2'b01}));
        check("w", 128'({m_wvalid, m_wvalid ? {m_wdata, m_wstrb, m_wlast} : 37'd0}),
                   128'({ewv, ewv ? {lsu_wdata, lsu_wstrb, lsu_wlast} : 37'd0}));
        check("rdy", 128'({ifu_arready, lsu_arready, lsu_awready, lsu_wready, m_rready, m_bready}),
                     128'({oi & m_arready, olr & m_arready, ow & m_awready, ow & m_wready,
                           oi ? ifu_rready : (olr & lsu_rready), ow & lsu_bready}));
        check("r_ifu", 128'({ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rvalid & ifu_rlast}),
                       oi ? 128'({m_rvalid, m_rdata, m_rresp, m_rvalid & m_rlast}) : 128'd0);
        check("r_lsu", 128'({lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rvalid & lsu_rlast}),
                       olr ? 128'({m_rvalid, m_rdata, m_rresp, m_rvalid & m_rlast}) : 128'd0);
        check("b", 128'({lsu_bvalid, lsu_bresp}), ow ? 128'({m_bvalid, m_bresp}) : 128'd0);
    endtask

    task automatic abandon();
        owner = 0;
        s_beats = 0; s_aw = 0; s_w = 0;
        m_rvalid = 0; m_bvalid = 0;
        if (ifu_ph != 1) begin ifu_ph = 0; ifu_arvalid = 0; end
        if (lr_ph != 1) begin lr_ph = 0; lsu_arvalid = 0; end
        if (!(lw_ph == 1 && lsu_awvalid && lsu_wvalid)) begin lw_ph = 0; lsu_awvalid = 0; lsu_wvalid = 0; end
    endtask

    task automatic apply_events();
        if (h_ar) begin
            if (owner == 1) begin ifu_arvalid = 0; ifu_ph = 2; end
            else begin lsu_arvalid = 0; lr_ph = 2; end
            s_beats = $urandom_range(1, 2);
        end
        if (h_r) begin
            m_rvalid = 0;
            s_beats--;
            if (h_r_last && owner == 1) begin ifu_ph = 0; ifu_done++; end
            if (h_r_last && owner == 2) begin lr_ph = 0; lsu_rd_done++; end
        end
        if (h_aw) begin lsu_awvalid = 0; s_aw = 1; end
        if (h_w) begin lsu_wvalid = 0; s_w = 1; end
        if (h_b) begin m_bvalid = 0; lw_ph = 0; lsu_wr_done++; end
        owner = nxt_owner;
    endtask

    task automatic drive_agents();
        m_arready = 1'($urandom); m_awready = 1'($urandom); m_wready = 1'($urandom);
        if (!m_rvalid) begin
            m_rdata = $urandom; m_rresp = 2'($urandom); m_rlast = 0;
            if (s_beats > 0 && $urandom_range(0, 2) != 0) begin m_rvalid = 1; m_rlast = s_beats == 1; end
        end
        if (s_aw && s_w && !m_bvalid) begin m_bvalid = 1; m_bresp = 2'($urandom); s_aw = 0; s_w = 0; end
        if (ifu_ph == 0 && $urandom_range(0, 3) == 0) begin
            ifu_arvalid = 1; ifu_araddr = $urandom; ifu_arsize = 3'($urandom); ifu_ph = 1;
        end
        if (lr_ph == 0 && $urandom_range(0, 5) == 0) begin
            lsu_arvalid = 1; lsu_araddr = $urandom; lsu_arsize = 3'($urandom); lr_ph = 1;
        end
        if (lw_ph == 0 && $urandom_range(0, 5) == 0) begin
            lsu_awvalid = 1; lsu_awaddr = $urandom; lsu_awsize = 3'($urandom);
            lsu_wvalid = 1; lsu_wdata = $urandom; lsu_wstrb = 4'($urandom); lsu_wlast = 1; lw_ph = 1;
        end
        ifu_rready = 1'($urandom); lsu_rready = 1'($urandom); lsu_bready = 1'($urandom);
    endtask

    task automatic observe_handshakes();
        logic rr;
        rr       = owner == 1 ? ifu_rready : (owner == 2 && lsu_rready);
        h_ar     = ((owner == 1 && ifu_arvalid) || (owner == 2 && lsu_arvalid)) && m_arready;
        h_r      = (owner == 1 || owner == 2) && m_rvalid && rr;
        h_r_last = h_r && m_rlast;
        h_aw     = owner == 3 && lsu_awvalid && m_awready;
        h_w      = owner == 3 && lsu_wvalid && m_wready;
        h_b      = owner == 3 && m_bvalid && lsu_bready;
        if (owner == 0) nxt_owner = lsu_awvalid ? 3 : lsu_arvalid ? 2 : ifu_arvalid ? 1 : 0;
        else            nxt_owner = (h_r_last || h_b) ? 0 : owner;
    endtask

    initial begin
        reset = 1;
        {ifu_arvalid, ifu_araddr, ifu_arsize, ifu_rready} = '0;
        {lsu_arvalid, lsu_araddr, lsu_arsize, lsu_rready} = '0;
        {lsu_awvalid, lsu_awaddr, lsu_awsize, lsu_wvalid, lsu_wdata, lsu_wstrb, lsu_wlast, lsu_bready} = '0;
        {m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rresp, m_rdata, m_rlast} = '0;
        owner = 0; nxt_owner = 0; ifu_ph = 0; lr_ph = 0; lw_ph = 0; s_beats = 0; s_aw = 0; s_w = 0;
        ifu_done = 0; lsu_rd_done = 0; lsu_wr_done = 0;
        {h_ar, h_r, h_r_last, h_aw, h_w, h_b, rst_now, after_rst} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 128'(up_flags()), 128'd0);
        reset = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (rst_now) abandon();
            else apply_events();
            after_rst = rst_now;
            drive_agents();
            rst_now = (c % 1000) == 999;
            reset = rst_now;
            #1;
            if (after_rst) check("rst_idle", 128'(up_flags()), 128'd0);
            check_cycle();
            observe_handshakes();
        end
        check("ifu_traffic", 128'(ifu_done > 20), 128'd1);
        check("lsu_rd_traffic", 128'(lsu_rd_done > 20), 128'd1);
        check("lsu_wr_traffic", 128'(lsu_wr_done > 20), 128'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
